// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - 4-digit multiplexed 7-segment scan scheduler with frame-synchronous word update.
// Define SEG_SCAN_LZ_BLANK_EN to enable leading-zero suppression.
module seg_scan_ctrl #(
    parameter int ON_CYC    = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load_valid,
    output logic        load_ready,
    output logic [6:0]  seg_out,
    output logic [3:0]  sel,
    output logic        frame_tick
);

    localparam int MAX_CYC = (ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam bit HAS_BLANK = (BLANK_CYC > 0);

    typedef enum logic {
        S_BLANK,
        S_ON
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] count, count_n;
    logic [1:0]    digit, digit_n;
    logic [15:0]   active, shadow;
    logic          pending;
    logic          transfer;
    logic          lz;
    logic [3:0]    nib;

    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0000100;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= HAS_BLANK ? S_BLANK : S_ON;
            count   <= '0;
            digit   <= '0;
            active  <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            digit <= digit_n;
            // A pending word is promoted at the boundary; transfers need pending low, so both never coincide.
            if (frame_tick && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (transfer) begin
                shadow  <= bcd_in;
                pending <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        count_n = count + CW'(1);
        digit_n = digit;
        case (state)
            S_BLANK: begin
                if (count == BLANK_LAST) begin
                    count_n = '0;
                    state_n = S_ON;
                end
            end
            S_ON: begin
                if (count == ON_LAST) begin
                    count_n = '0;
                    digit_n = digit + 2'd1;
                    state_n = HAS_BLANK ? S_BLANK : S_ON;
                end
            end
            default: begin
                count_n = '0;
                state_n = S_BLANK;
            end
        endcase
    end

    always_comb begin
        nib = active[{digit, 2'b00} +: 4];
        lz  = 1'b0;
`ifdef SEG_SCAN_LZ_BLANK_EN
        case (digit)
            2'd1:    lz = (active[15:4] == 12'h000);
            2'd2:    lz = (active[15:8] == 8'h00);
            2'd3:    lz = (active[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
`endif
        sel        = (state == S_ON) ? (4'b0001 << digit) : 4'b0000;
        seg_out    = ((state == S_ON) && !lz) ? seg_decode(nib) : 7'h7F;
        frame_tick = (state == S_ON) && (digit == 2'd3) && (count == ON_LAST);
        load_ready = ~pending;
        transfer   = load_valid && !pending;
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - directed scoreboard bench for seg_scan_ctrl with ON_CYC=4, BLANK_CYC=2.
module tb_seg_scan_ctrl;

    localparam int ON_CYC    = 4;
    localparam int BLANK_CYC = 2;
    localparam int PH        = ON_CYC + BLANK_CYC;
    localparam int FRAME     = 4 * PH;
    localparam int NONE      = -1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bcd_in = 16'h0000;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [6:0]  seg_out;
    logic [3:0]  sel;
    logic        frame_tick;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] m_active;
    logic        m_pending;
    logic [15:0] word_q[$];

    seg_scan_ctrl #(.ON_CYC(ON_CYC), .BLANK_CYC(BLANK_CYC)) dut (
        .clk        (clk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg_out    (seg_out),
        .sel        (sel),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [15:0] w, input int d);
        logic [3:0] n;
        n = w[4*d +: 4];
`ifdef SEG_SCAN_LZ_BLANK_EN
        if (d > 0 && (w >> (4 * d)) == 16'h0000) return 7'h7F;
`endif
        case (n)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs frame cycles first..last from a negedge sample point; two optional input changes per span.
    task automatic run_span(input int first, input int last,
                            input int a_at, input logic [15:0] a_word,
                            input int b_at, input logic b_valid, input logic [15:0] b_word);
        for (int i = first; i <= last; i++) begin
            int         ph;
            int         d;
            logic [3:0] es;
            logic [6:0] eg;
            logic       xfer;
            logic       apply;
            if (i == a_at) begin
                load_valid = 1'b1;
                bcd_in     = a_word;
            end
            if (i == b_at) begin
                load_valid = b_valid;
                bcd_in     = b_word;
            end
            ph = i % PH;
            d  = i / PH;
            if (ph < BLANK_CYC) begin
                es = 4'b0000;
                eg = 7'h7F;
            end else begin
                es = 4'b0001 << d;
                eg = ref_seg(m_active, d);
            end
            check($sformatf("sel c%0d", i), {12'h000, sel}, {12'h000, es});
            check($sformatf("seg c%0d", i), {9'h000, seg_out}, {9'h000, eg});
            check($sformatf("tick c%0d", i), {15'h0000, frame_tick}, {15'h0000, (i == FRAME - 1)});
            check($sformatf("ready c%0d", i), {15'h0000, load_ready}, {15'h0000, ~m_pending});
            apply = (i == FRAME - 1) && m_pending;
            xfer  = load_valid && !m_pending;
            if (apply) begin
                if (word_q.size() > 0) m_active = word_q.pop_front();
                m_pending = 1'b0;
            end else if (xfer) begin
                word_q.push_back(bcd_in);
                m_pending = 1'b1;
            end
            @(negedge clk);
        end
    endtask

    task automatic idle_frame();
        run_span(0, FRAME - 1, NONE, 16'h0000, NONE, 1'b0, 16'h0000);
    endtask

    initial begin
        m_active  = 16'h0000;
        m_pending = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst sel", {12'h000, sel}, 16'h0000);
        check("rst seg", {9'h000, seg_out}, 16'h007F);
        check("rst ready", {15'h0000, load_ready}, 16'h0001);
        check("rst tick", {15'h0000, frame_tick}, 16'h0000);
        rst = 1'b0;

        idle_frame();
        idle_frame();

        run_span(0, FRAME - 1, 8, 16'h1234, 9, 1'b0, 16'h0000);
        idle_frame();

        run_span(0, FRAME - 1, 3, 16'h0001, 4, 1'b1, 16'h0002);
        run_span(0, FRAME - 1, NONE, 16'h0000, 1, 1'b0, 16'h0000);
        idle_frame();

        run_span(0, FRAME - 1, 5, 16'h00A5, 6, 1'b0, 16'h0000);
        idle_frame();

        run_span(0, 15, 2, 16'h5678, 3, 1'b0, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        check("midrst sel", {12'h000, sel}, 16'h0000);
        check("midrst seg", {9'h000, seg_out}, 16'h007F);
        check("midrst ready", {15'h0000, load_ready}, 16'h0001);
        rst = 1'b0;
        m_active  = 16'h0000;
        m_pending = 1'b0;
        word_q.delete();
        idle_frame();
        idle_frame();

        run_span(0, FRAME - 1, 4, 16'h0070, 5, 1'b0, 16'h0000);
        idle_frame();
        run_span(0, FRAME - 1, 4, 16'h0000, 5, 1'b0, 16'h0000);
        idle_frame();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
